// File: rtl/seg_value_formatter.sv
// Converts signed 12-bit pairs to BCD via a shared double-dabble FSM and
// serves an eight-digit display buffer to the seven-segment driver.
module seg_value_formatter #(
    parameter bit SIGN_DP = 1'b1
) (
    input  logic        clk_100mhz,
    input  logic        nrst,
    input  logic [11:0] in_a,
    input  logic [11:0] in_b,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        upd,
    input  logic [2:0]  can,
    output logic [3:0]  val,
    output logic        d,
    output logic        valid
);

    typedef enum logic [1:0] {IDLE, SHIFT_A, SHIFT_B, COMMIT} state_t;

    state_t          state;
    logic [3:0]      cnt;
    logic [27:0]     sr;
    logic [27:0]     sr_adj;
    logic [27:0]     sr_next;
    logic            sign_a;
    logic            sign_b;
    logic [11:0]     mag_b;
    logic [15:0]     bcd_a;
    logic [7:0][3:0] buf_val;
    logic [7:0]      buf_vld;
    logic [7:0]      buf_dp;

    function automatic logic [11:0] magnitude(input logic [11:0] x);
        return x[11] ? (~x + 12'd1) : x;
    endfunction

    // {digits, valid mask, decimal-point mask} for one four-digit group
    function automatic logic [23:0] group(input logic [15:0] bcd,
                                          input logic neg);
        logic [3:0] vld;
        logic [3:0] dp;
        vld[3] = bcd[15:12] != 4'd0;
        vld[2] = vld[3] | (bcd[11:8] != 4'd0);
        vld[1] = vld[2] | (bcd[7:4] != 4'd0);
        vld[0] = 1'b1;
        dp = '0;
        if (SIGN_DP && neg)
            dp = vld & ~{1'b0, vld[3:1]};
        return {bcd, vld, dp};
    endfunction

    always_comb begin
        sr_adj = sr;
        for (int i = 0; i < 4; i++) begin
            if (sr[12+4*i +: 4] >= 4'd5)
                sr_adj[12+4*i +: 4] = sr[12+4*i +: 4] + 4'd3;
        end
        sr_next = {sr_adj[26:0], 1'b0};
    end

    always_ff @(posedge clk_100mhz or negedge nrst) begin
        if (!nrst) begin
            state   <= IDLE;
            cnt     <= '0;
            sr      <= '0;
            sign_a  <= 1'b0;
            sign_b  <= 1'b0;
            mag_b   <= '0;
            bcd_a   <= '0;
            upd     <= 1'b0;
            buf_val <= '0;
            buf_vld <= 8'h11;
            buf_dp  <= '0;
        end else begin
            upd <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_a <= in_a[11];
                        sign_b <= in_b[11];
                        mag_b  <= magnitude(in_b);
                        sr     <= {16'd0, magnitude(in_a)};
                        cnt    <= '0;
                        state  <= SHIFT_A;
                    end
                end
                SHIFT_A: begin
                    cnt <= cnt + 4'd1;
                    sr  <= sr_next;
                    if (cnt == 4'd11) begin
                        bcd_a <= sr_next[27:12];
                        sr    <= {16'd0, mag_b};
                        cnt   <= '0;
                        state <= SHIFT_B;
                    end
                end
                SHIFT_B: begin
                    cnt <= cnt + 4'd1;
                    sr  <= sr_next;
                    if (cnt == 4'd11) begin
                        cnt   <= '0;
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    {buf_val[7:4], buf_vld[7:4], buf_dp[7:4]}
                        <= group(bcd_a, sign_a);
                    {buf_val[3:0], buf_vld[3:0], buf_dp[3:0]}
                        <= group(sr[27:12], sign_b);
                    upd   <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready = (state == IDLE);
    assign val      = buf_val[can];
    assign d        = buf_dp[can];
    assign valid    = buf_vld[can];

endmodule

// File: tb/tb_seg_value_formatter.sv
// Random and directed checks of seg_value_formatter against a
// decimal-arithmetic display model, for SIGN_DP=1 and SIGN_DP=0.
`timescale 1ns/1ps
module tb_seg_value_formatter;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic [11:0] in_a = '0;
    logic [11:0] in_b = '0;
    logic        in_valid = 1'b0;
    logic [2:0]  can = '0;

    logic        ready1, upd1, d1, valid1;
    logic [3:0]  val1;
    logic        ready0, upd0, d0, valid0;
    logic [3:0]  val0;

    seg_value_formatter #(.SIGN_DP(1'b1)) dut1 (
        .clk_100mhz(clk), .nrst(nrst),
        .in_a(in_a), .in_b(in_b), .in_valid(in_valid),
        .in_ready(ready1), .upd(upd1), .can(can),
        .val(val1), .d(d1), .valid(valid1)
    );

    seg_value_formatter #(.SIGN_DP(1'b0)) dut0 (
        .clk_100mhz(clk), .nrst(nrst),
        .in_a(in_a), .in_b(in_b), .in_valid(in_valid),
        .in_ready(ready0), .upd(upd0), .can(can),
        .val(val0), .d(d0), .valid(valid0)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endtask

    // Display model: shown pair plus pending pair and cycles-to-visible
    int sh_a = 0, sh_b = 0, pend_a = 0, pend_b = 0, rem = 0;
    bit m_ready = 1'b1, m_upd = 1'b0;

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sh_a = 0; sh_b = 0; rem = 0;
            m_ready = 1'b1; m_upd = 1'b0;
        end else begin
            m_upd = 1'b0;
            if (rem > 0) begin
                rem--;
                if (rem == 0) begin
                    sh_a = pend_a; sh_b = pend_b;
                    m_upd = 1'b1; m_ready = 1'b1;
                end
            end else if (in_valid && m_ready) begin
                pend_a = int'($signed(in_a));
                pend_b = int'($signed(in_b));
                rem = 25;
                m_ready = 1'b0;
            end
        end
    end

    function automatic void exp_pos(input int a, input int b,
                                    input int pos, input bit sdp,
                                    output int ev, output int evl,
                                    output int ed);
        int v, m, p, pw;
        v = (pos >= 4) ? a : b;
        m = (v < 0) ? -v : v;
        p = pos % 4;
        pw = (p == 0) ? 1 : (p == 1) ? 10 : (p == 2) ? 100 : 1000;
        ev = (m / pw) % 10;
        evl = (p == 0 || m >= pw) ? 1 : 0;
        ed = (sdp && v < 0 && evl == 1 && (p == 3 || m < pw * 10)) ? 1 : 0;
    endfunction

    int cv, cl, cd;
    always @(negedge clk) begin
        exp_pos(sh_a, sh_b, int'(can), 1'b1, cv, cl, cd);
        chk("val1", int'(val1), cv);
        chk("valid1", int'(valid1), cl);
        chk("d1", int'(d1), cd);
        chk("ready1", int'(ready1), int'(m_ready));
        chk("upd1", int'(upd1), int'(m_upd));
        exp_pos(sh_a, sh_b, int'(can), 1'b0, cv, cl, cd);
        chk("val0", int'(val0), cv);
        chk("valid0", int'(valid0), cl);
        chk("d0", int'(d0), cd);
        chk("ready0", int'(ready0), int'(m_ready));
        chk("upd0", int'(upd0), int'(m_upd));
    end

    task automatic lit(input string tag, input int pos, input int ev,
                       input int evl, input int ed);
        can = 3'(pos);
        #1;
        chk({tag, "_val"}, int'(val1), ev);
        chk({tag, "_valid"}, int'(valid1), evl);
        chk({tag, "_d"}, int'(d1), ed);
        chk({tag, "_val0"}, int'(val0), ev);
        chk({tag, "_d0"}, int'(d0), 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        can = 3'($urandom_range(7));
    endtask

    task automatic accept(output time t);
        t = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ready1 && in_valid) begin
                @(posedge clk);
                t = $time;
                #2;
                return;
            end
        end
        chk("accept_timeout", 0, 1);
    endtask

    task automatic wait_upd(output time t);
        t = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (upd1) begin
                t = $time;
                #1;
                return;
            end
        end
        chk("upd_timeout", 0, 1);
    endtask

    task automatic send(input int a, input int b, output int lat);
        time ta, tu;
        in_a = 12'(a);
        in_b = 12'(b);
        in_valid = 1'b1;
        accept(ta);
        in_valid = 1'b0;
        wait_upd(tu);
        lat = int'((tu - (ta - 5)) / 10);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        time t1, t2;
        repeat (2) @(posedge clk);
        #2 nrst = 1'b1;
        for (int p = 0; p < 8; p++)
            lit("rst", p, 0, (p == 0 || p == 4) ? 1 : 0, 0);
        chk("rst_ready", int'(ready1), 1);
        chk("rst_upd", int'(upd1), 0);

        send(1234, -56, lat);
        chk("lat_1234", lat, 26);
        lit("p7", 7, 1, 1, 0);
        lit("p6", 6, 2, 1, 0);
        lit("p5", 5, 3, 1, 0);
        lit("p4", 4, 4, 1, 0);
        lit("p3", 3, 0, 0, 0);
        lit("p2", 2, 0, 0, 0);
        lit("p1", 1, 5, 1, 1);
        lit("p0", 0, 6, 1, 0);

        send(-2048, 2047, lat);
        lit("e7", 7, 2, 1, 1);
        lit("e6", 6, 0, 1, 0);
        lit("e5", 5, 4, 1, 0);
        lit("e4", 4, 8, 1, 0);
        lit("e3", 3, 2, 1, 0);
        lit("e2", 2, 0, 1, 0);
        lit("e1", 1, 4, 1, 0);
        lit("e0", 0, 7, 1, 0);

        in_a = 12'd7;
        in_b = 12'hFFF;
        in_valid = 1'b1;
        accept(t1);
        in_a = 12'd100;
        in_b = 12'd0;
        accept(t2);
        chk("b2b_gap", int'((t2 - t1) / 10), 26);
        repeat (3) tick();
        lit("b4", 4, 7, 1, 0);
        lit("b5", 5, 0, 0, 0);
        lit("b0", 0, 1, 1, 1);
        in_valid = 1'b0;
        wait_upd(t1);
        lit("c6", 6, 1, 1, 0);
        lit("c5", 5, 0, 1, 0);
        lit("c4", 4, 0, 1, 0);
        lit("c7", 7, 0, 0, 0);
        lit("c0", 0, 0, 1, 0);
        lit("c1", 1, 0, 0, 0);

        in_a = 12'd1500;
        in_b = 12'd3;
        in_valid = 1'b1;
        accept(t1);
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #2 nrst = 1'b0;
        #1;
        chk("ar_ready", int'(ready1), 1);
        chk("ar_upd", int'(upd1), 0);
        for (int p = 0; p < 8; p++)
            lit("ar", p, 0, (p == 0 || p == 4) ? 1 : 0, 0);
        #10 nrst = 1'b1;
        repeat (40) tick();
        send(1500, 3, lat);
        chk("lat_1500", lat, 26);
        lit("f7", 7, 1, 1, 0);
        lit("f6", 6, 5, 1, 0);
        lit("f5", 5, 0, 1, 0);
        lit("f4", 4, 0, 1, 0);
        lit("f3", 3, 0, 0, 0);
        lit("f0", 0, 3, 1, 0);

        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(3)) tick();
            send($urandom_range(4095) - 2048,
                 $urandom_range(4095) - 2048, lat);
            chk("lat_rand", lat, 26);
        end

        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_a = 12'($urandom);
            in_b = 12'($urandom);
            accept(t1);
            repeat ($urandom_range(5)) tick();
        end
        in_valid = 1'b0;
        repeat (30) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/seg_value_formatter.md
# seg_value_formatter

Feeder for the eight-digit seven-segment driver. It accepts pairs of signed 12-bit readings, such as two accelerometer axes, through a valid/ready handshake. Each value is converted to decimal with an iterative double-dabble FSM and committed atomically to an eight-digit display buffer. The block answers the driver's anode index with the digit value, decimal-point and digit-valid signals for that position in the same cycle.

## Interface
- SIGN_DP, default 1: when 1, a negative value is marked by the decimal point of its leftmost displayed digit; when 0, `d` is always 0.

- clk_100mhz  in  1  system clock
- nrst  in  1  reset, asynchronous, active-low
- in_a  in  12  signed two's-complement value for the left group, digits 7..4
- in_b  in  12  signed two's-complement value for the right group, digits 3..0
- in_valid  in  1  producer has a pair on in_a/in_b
- in_ready  out  1  block is idle and can accept a pair
- upd  out  1  one-cycle pulse: the new pair became visible this cycle
- can  in  3  current anode index from the display driver; 0 is the rightmost digit
- val  out  4  BCD digit for position `can`, always 0..9
- d  out  1  decimal point for position `can`
- valid  out  1  position `can` is lit; 0 means blanked

## Operation
- States: IDLE, SHIFT_A, SHIFT_B, COMMIT.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready, latch in_a and in_b and go to SHIFT_A.
  - For each channel, store the sign and |x| as a 12-bit unsigned magnitude; |−2048| = 2048.
- SHIFT_A: 12 cycles of double dabble on a 16-bit BCD and 12-bit magnitude shift register.
  - Each cycle, add 3 to every BCD nibble ≥5, then shift left 1 with the magnitude MSB entering the BCD LSB.
  - A 4-bit iteration counter counts 0..11; the state exits after count 11.
- SHIFT_B: identical to SHIFT_A, for channel B. A single converter is shared by both channels.
- COMMIT, one cycle, writes the display buffer for both groups. Per group, digit positions are p=3..0.
  - Digit p is valid iff any BCD digit at position ≥p is nonzero. Position 0 is always valid, so a value of 0 shows a single "0".
  - If SIGN_DP=1 and the value is negative, d=1 only on the highest valid position of the group. All other positions have d=0.
  - Buffer contents per digit: 4-bit value, valid bit, d bit (8×6 bits). After COMMIT the FSM returns to IDLE.
- in_valid outside IDLE is ignored. The producer must hold the pair until in_ready is high.
- The display buffer changes only in COMMIT. During conversion the old pair stays displayed with no partial or torn digits.
- val/d/valid are a combinational mux of the buffer entry indexed by `can`, with zero latency, because the driver samples them in the cycle it drives `can`.
- Asynchronous reset at any point aborts the conversion and discards the latched pair.
  - Reset state: FSM IDLE, counter 0, upd=0, in_ready=1.
  - Buffer after reset: both groups hold 0 (positions 4 and 0 valid with val=0; all other positions invalid), all d=0, all val=0.

## Timing
- Accept at cycle T: the cycle where in_valid && in_ready.
- SHIFT_A occupies T+1..T+12, SHIFT_B T+13..T+24, COMMIT T+25.
- The new buffer is visible from T+26. upd=1 in T+26 only.
- in_ready is low in T+1..T+25 and high again from T+26. The next accept can occur at T+26, giving a 26-cycle minimum period per pair.
- Output mux: a `can` change is reflected on val/d/valid in the same cycle.

## Test plan
- Reset, then sweep can 0..7:
  - can=0 and can=4: val=0, valid=1, d=0.
  - All other positions: valid=0, d=0.
  - in_ready=1, upd=0.
- Send in_a=1234, in_b=−56:
  - upd arrives exactly 26 cycles after accept.
  - can 7..4 give val 1,2,3,4, all valid, all d=0.
  - can 3 and 2 give valid=0.
  - can 1 gives val=5, valid=1, d=1.
  - can 0 gives val=6, valid=1, d=0.
- Send in_a=−2048, in_b=2047:
  - can 7..4 give 2,0,4,8 with d=1 only on can 7.
  - can 3..0 give 2,0,4,7 with d=0.
  - Repeat with SIGN_DP=0: all d=0.
- Back-to-back pairs (7, −1) then (100, 0), with in_valid held high throughout:
  - The second pair is accepted exactly 26 cycles after the first.
  - The display shows (7, −1) until the second upd: can 4 val=7, can 0 val=1 d=1.
  - After the second upd, can 6..4 give 1,0,0 and can 0 gives 0.
- Assert nrst at cycle T+10 of a conversion of (9999-range value 1500, 3):
  - All outputs take their reset values immediately.
  - No upd occurs.
  - The display reads the reset pattern; a fresh accept after release converts correctly.
